// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data memory sequencer with a pipeline/loader
// round-robin arbiter. Loader port enabled by DMEM_ACCESS_CTRL_LOADER_EN.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pipe_memread,
  input  logic              pipe_memwrite,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_stall,
  output logic              pipe_done,
  output logic [DATA_W-1:0] pipe_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_result
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              own_q, own_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [DATA_W-1:0] lrdata_q, lrdata_d;

  logic pipe_req;
  logic ld_req_w;
  logic ld_win;
  logic pipe_win;

  assign pipe_req = pipe_memread | pipe_memwrite;

`ifdef DMEM_ACCESS_CTRL_LOADER_EN
  assign ld_req_w = ld_req;
`else
  assign ld_req_w = 1'b0;
`endif

  // last_q=1 means the loader was served last, so the pipeline wins a tie
  assign ld_win   = ld_req_w & (~pipe_req | ~last_q);
  assign pipe_win = pipe_req & ~ld_win;

  // Next-state: grant/latch in IDLE, count down in BUSY, one RESP cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    own_d    = own_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    lrdata_d = lrdata_q;
    unique case (state_q)
      IDLE: begin
        if (pipe_win | ld_win) begin
          own_d   = ld_win;
          last_d  = ld_win;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
          if (ld_win) begin
            wr_d    = ld_we;
            rd_d    = ~ld_we;
            addr_d  = ld_addr;
            wdata_d = ld_wdata;
          end else begin
            wr_d    = pipe_memwrite;
            rd_d    = ~pipe_memwrite;
            addr_d  = pipe_addr;
            wdata_d = pipe_wdata;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          if (rd_q) begin
            if (own_q) lrdata_d = mem_result;
            else       prdata_d = mem_result;
          end
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      own_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
      lrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      own_q    <= own_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
      lrdata_q <= lrdata_d;
    end
  end

  assign mem_read       = rd_q;
  assign mem_write      = wr_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

  assign pipe_done  = (state_q == RESP) & ~own_q;
  assign ld_done    = (state_q == RESP) & own_q;
  assign ld_gnt     = (state_q == IDLE) & ld_win;
  assign pipe_stall = pipe_req & ~pipe_done;
  assign pipe_rdata = prdata_q;
  assign ld_rdata   = lrdata_q;

endmodule
